// File: rtl/scan_line_sequencer.sv
// scan_line_sequencer: per-line settle/transmit/receive timing, depth gate and markers,
// bouncing beam angle handed to the line store over valid/ready.
module scan_line_sequencer #(
  parameter int SETTLE_CYCLES = 20000,
  parameter int TX_CYCLES     = 50,
  parameter int RX_CYCLES     = 2000,
  parameter int CM_CYCLES     = 65,
  parameter int ANGLE_MAX     = 90
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       on,
  input  logic       home,
  input  logic       line_ready,
  output logic       increment,
  output logic       transmit,
  output logic       receive,
  output logic       z_on,
  output logic       markers,
  output logic       line_valid,
  output logic [7:0] line_angle
);
  typedef enum logic [2:0] {IDLE, SETTLE, TX, RX, HANDOFF} state_t;
  localparam logic [7:0] AMAX = 8'(ANGLE_MAX);
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n, dcnt, dcnt_n;
  logic [7:0]  angle_n;
  logic        up, up_n;
  logic        increment_n, transmit_n, receive_n, z_on_n, markers_n, line_valid_n;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cnt        <= '0;
      dcnt       <= '0;
      line_angle <= '0;
      up         <= 1'b1;
      increment  <= 1'b0;
      transmit   <= 1'b0;
      receive    <= 1'b0;
      z_on       <= 1'b0;
      markers    <= 1'b0;
      line_valid <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      dcnt       <= dcnt_n;
      line_angle <= angle_n;
      up         <= up_n;
      increment  <= increment_n;
      transmit   <= transmit_n;
      receive    <= receive_n;
      z_on       <= z_on_n;
      markers    <= markers_n;
      line_valid <= line_valid_n;
    end
  end
  always_comb begin
    state_n = state;
    angle_n = line_angle;
    up_n    = up;
    case (state)
      IDLE: begin
        if (home) begin
          angle_n = '0;
          up_n    = 1'b1;
        end
        if (on) state_n = SETTLE;
      end
      SETTLE:  if (cnt == 16'(SETTLE_CYCLES - 1)) state_n = TX;
      TX:      if (cnt == 16'(TX_CYCLES - 1)) state_n = RX;
      RX:      if (cnt == 16'(RX_CYCLES - 1)) state_n = HANDOFF;
      HANDOFF: if (line_ready) begin
        if (home) begin
          angle_n = '0;
          up_n    = 1'b1;
        end else if (up) begin
          angle_n = (line_angle == AMAX) ? AMAX - 8'd1 : line_angle + 8'd1;
          up_n    = line_angle != AMAX;
        end else begin
          angle_n = (line_angle == 8'd0) ? 8'd1 : line_angle - 8'd1;
          up_n    = line_angle == 8'd0;
        end
        state_n = on ? SETTLE : IDLE;
      end
      default: state_n = IDLE;
    endcase
    cnt_n  = (state_n != state) ? '0 : cnt + 16'd1;
    dcnt_n = (state_n != RX || state != RX || dcnt == 16'(CM_CYCLES - 1)) ? '0 : dcnt + 16'd1;
  end
  // Outputs are decoded from the next-cycle values so they leave the block registered.
  always_comb begin
    increment_n  = state_n == SETTLE && cnt_n == '0;
    transmit_n   = state_n == TX;
    receive_n    = state_n == RX;
    z_on_n       = state_n == RX && cnt_n >= 16'(CM_CYCLES);
    markers_n    = state_n == RX && dcnt_n == '0 && cnt_n != '0;
    line_valid_n = state_n == HANDOFF;
  end
endmodule

// File: tb/tb_scan_line_sequencer.sv
// tb_scan_line_sequencer: directed checks of line shape, bounce, backpressure, stop,
// async reset and home using reduced timing parameters.
module tb_scan_line_sequencer;
  logic       clock = 1'b0;
  logic       resetn, on, home, line_ready;
  logic       increment, transmit, receive, z_on, markers, line_valid;
  logic [7:0] line_angle;
  logic [5:0] obs, exp_v;
  int         vectors = 0;
  int         errors  = 0;

  scan_line_sequencer #(
    .SETTLE_CYCLES(4), .TX_CYCLES(2), .RX_CYCLES(10), .CM_CYCLES(3), .ANGLE_MAX(3)
  ) dut (
    .clock(clock), .resetn(resetn), .on(on), .home(home), .line_ready(line_ready),
    .increment(increment), .transmit(transmit), .receive(receive), .z_on(z_on),
    .markers(markers), .line_valid(line_valid), .line_angle(line_angle)
  );

  always #5 clock = ~clock;
  assign obs = {increment, transmit, receive, z_on, markers, line_valid};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; on = 1'b0; home = 1'b0; line_ready = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; on = 1'b1; home = 1'b0; line_ready = 1'b1;
    #1;
    vectors++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_outputs got %b exp %b", obs, 6'b0); end
    vectors++;
    if (line_angle !== 8'd0) begin errors++; $display("FAIL reset_angle got %0d exp 0", line_angle); end
    tick();
    vectors++;
    if (obs !== 6'b0) begin errors++; $display("FAIL reset_held got %b exp %b", obs, 6'b0); end
    resetn = 1'b1;
  endtask

  task automatic test_line_shape();
    do_reset();
    on = 1'b1; line_ready = 1'b1;
    for (int n = 1; n <= 34; n++) begin
      int k;
      k = ((n - 1) % 17) + 1;
      tick();
      exp_v = {k == 1, k == 5 || k == 6, k >= 7 && k <= 16, k >= 10 && k <= 16,
               k == 10 || k == 13 || k == 16, k == 17};
      vectors++;
      if (obs !== exp_v) begin errors++; $display("FAIL shape cycle=%0d got %b exp %b", n, obs, exp_v); end
    end
  endtask

  task automatic test_bounce();
    int exp_a [8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    do_reset();
    on = 1'b1; line_ready = 1'b1;
    for (int l = 0; l < 8; l++)
      for (int k = 1; k <= 17; k++) begin
        tick();
        if (k == 1 || k == 17) begin
          vectors++;
          if (line_angle !== 8'(exp_a[l]) || (k == 17 && line_valid !== 1'b1))
            begin errors++; $display("FAIL bounce line=%0d k=%0d got angle %0d valid %b exp angle %0d", l, k, line_angle, line_valid, exp_a[l]); end
        end
      end
  endtask

  task automatic test_backpressure();
    do_reset();
    on = 1'b1; line_ready = 1'b0;
    for (int k = 1; k <= 16; k++) tick();
    for (int k = 17; k <= 22; k++) begin
      tick();
      vectors++;
      if (obs !== 6'b000001 || line_angle !== 8'd0)
        begin errors++; $display("FAIL backpressure k=%0d got %b angle %0d exp 000001 angle 0", k, obs, line_angle); end
    end
    line_ready = 1'b1;
    tick();
    vectors++;
    if (obs !== 6'b100000 || line_angle !== 8'd1)
      begin errors++; $display("FAIL bp_restart got %b angle %0d exp 100000 angle 1", obs, line_angle); end
  endtask

  task automatic test_stop();
    do_reset();
    on = 1'b1; line_ready = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    on = 1'b0;
    for (int k = 11; k <= 16; k++) begin
      tick();
      vectors++;
      if (receive !== 1'b1) begin errors++; $display("FAIL stop_rx k=%0d got %b exp 1", k, receive); end
    end
    tick();
    vectors++;
    if (obs !== 6'b000001 || line_angle !== 8'd0)
      begin errors++; $display("FAIL stop_handoff got %b angle %0d exp 000001 angle 0", obs, line_angle); end
    for (int k = 18; k <= 21; k++) begin
      tick();
      vectors++;
      if (obs !== 6'b0 || line_angle !== 8'd1)
        begin errors++; $display("FAIL stop_idle k=%0d got %b angle %0d exp 000000 angle 1", k, obs, line_angle); end
    end
    on = 1'b1;
    tick();
    vectors++;
    if (obs !== 6'b100000 || line_angle !== 8'd1)
      begin errors++; $display("FAIL stop_resume got %b angle %0d exp 100000 angle 1", obs, line_angle); end
    for (int k = 2; k <= 17; k++) tick();
    vectors++;
    if (line_valid !== 1'b1 || line_angle !== 8'd1)
      begin errors++; $display("FAIL stop_resume_handoff got valid %b angle %0d exp 1 angle 1", line_valid, line_angle); end
  endtask

  task automatic test_async_reset();
    do_reset();
    on = 1'b1; line_ready = 1'b1;
    for (int n = 1; n <= 22; n++) tick();
    vectors++;
    if (transmit !== 1'b1 || line_angle !== 8'd1)
      begin errors++; $display("FAIL ar_pre got tx %b angle %0d exp tx 1 angle 1", transmit, line_angle); end
    #2 resetn = 1'b0;
    #1;
    vectors++;
    if (obs !== 6'b0 || line_angle !== 8'd0)
      begin errors++; $display("FAIL ar_immediate got %b angle %0d exp 000000 angle 0", obs, line_angle); end
    tick();
    resetn = 1'b1;
    tick();
    vectors++;
    if (obs !== 6'b100000 || line_angle !== 8'd0)
      begin errors++; $display("FAIL ar_restart got %b angle %0d exp 100000 angle 0", obs, line_angle); end
    for (int k = 2; k <= 17; k++) tick();
    vectors++;
    if (line_valid !== 1'b1 || line_angle !== 8'd0)
      begin errors++; $display("FAIL ar_handoff got valid %b angle %0d exp 1 angle 0", line_valid, line_angle); end
  endtask

  task automatic test_home();
    do_reset();
    on = 1'b1; line_ready = 1'b1;
    for (int n = 1; n <= 85; n++) tick();
    vectors++;
    if (line_valid !== 1'b1 || line_angle !== 8'd2)
      begin errors++; $display("FAIL home_pre got valid %b angle %0d exp 1 angle 2", line_valid, line_angle); end
    home = 1'b1;
    tick();
    home = 1'b0;
    vectors++;
    if (increment !== 1'b1 || line_angle !== 8'd0)
      begin errors++; $display("FAIL home_line got inc %b angle %0d exp 1 angle 0", increment, line_angle); end
    for (int k = 2; k <= 17; k++) tick();
    tick();
    vectors++;
    if (increment !== 1'b1 || line_angle !== 8'd1)
      begin errors++; $display("FAIL home_next got inc %b angle %0d exp 1 angle 1", increment, line_angle); end
  endtask

  initial begin
    test_reset();
    test_line_shape();
    test_bounce();
    test_backpressure();
    test_stop();
    test_async_reset();
    test_home();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/scan_line_sequencer.md
# scan_line_sequencer

Scan-line sequencer for the 2-D ultrasound probe. It runs on the 5 MHz clock and produces the per-line settle, transmit and receive windows, the depth gate and the 1 cm depth markers. It steps the beam angle back and forth across the sector and hands each finished line's angle to the downstream line store through a valid/ready handshake. It replaces free-running line timing with a single registered controller that waits for the consumer and can be stopped cleanly between lines.

## Interface
Parameters:
- SETTLE_CYCLES, 20000: cycles per line for stepper settle; must be ≥1.
- TX_CYCLES, 50: transmit burst length (10 µs at 5 MHz); must be ≥1.
- RX_CYCLES, 2000: receive window length; must be ≥1.
- CM_CYCLES, 65: cycles per 1 cm of echo depth; must be ≥1.
- ANGLE_MAX, 90: top of the angle sweep; must be between 1 and 255.

Ports:
- clock  in  1  5 MHz system clock.
- resetn  in  1  asynchronous, active-low reset.
- on  in  1  run enable; sampled only in IDLE and HANDOFF.
- home  in  1  forces the next line to angle 0, direction up.
- line_ready  in  1  downstream store can accept a line.
- increment  out  1  one-cycle stepper step pulse.
- transmit  out  1  transmit burst gate.
- receive  out  1  receive window gate.
- z_on  out  1  depth gate; high once echo depth ≥1 cm.
- markers  out  1  one-cycle pulse at each 1 cm of depth.
- line_valid  out  1  finished line available.
- line_angle  out  8  beam angle of the current line, 0..ANGLE_MAX.

## Operation
- **State register.** The states are IDLE, SETTLE, TX, RX and HANDOFF. A 16-bit phase counter `cnt` clears on every state change. A separate depth counter `dcnt` counts 0..CM_CYCLES-1 and is used instead of a modulo.
- **Reset.** On resetn low:
  - state goes to IDLE.
  - `cnt`, `dcnt` and the angle clear to 0.
  - direction goes to up.
  - all outputs go to 0 asynchronously.
- **IDLE.**
  - If `home` is high, the angle goes to 0 and direction to up.
  - If `on` is high, the block goes to SETTLE. The angle is not stepped on this entry.
- **SETTLE.**
  - `increment` is high only in the cycle where `cnt`=0.
  - The state lasts SETTLE_CYCLES cycles, then goes to TX.
- **TX.** `transmit` is high for all TX_CYCLES cycles, then the state goes to RX.
- **RX.**
  - `receive` is high for all RX_CYCLES cycles.
  - `dcnt` starts at 0 on entry and wraps at CM_CYCLES-1.
  - `markers` is high when `dcnt`=0 and `cnt`≠0.
  - `z_on` is high when `cnt`≥CM_CYCLES.
  - After RX_CYCLES cycles the state goes to HANDOFF.
- **HANDOFF.**
  - `line_valid` is high and `line_angle` is held stable until `line_ready` is high.
  - On the cycle where `line_valid` and `line_ready` are both high:
    - If `home` is high, the angle goes to 0 and direction to up.
    - Otherwise the angle steps as described under "Angle step".
    - Then, if `on` is high, the state goes to SETTLE; otherwise it goes to IDLE.
- **Angle step (bounce).**
  - Direction up, angle < ANGLE_MAX: angle+1.
  - Direction up, angle = ANGLE_MAX: direction flips to down and the angle becomes ANGLE_MAX-1.
  - Direction down, angle > 0: angle-1.
  - Direction down, angle = 0: direction flips to up and the angle becomes 1.
  - The angle never leaves the range 0..ANGLE_MAX.
- **on dropped mid-line.** The current line completes through HANDOFF, then the block returns to IDLE. No partial lines are produced.
- **line_ready high outside HANDOFF.** It is ignored.

## Timing
- All outputs come directly from registers; there are no combinational input-to-output paths.
- `increment` is high in the first cycle of SETTLE, which is the cycle after the IDLE→SETTLE or HANDOFF→SETTLE edge.
- `line_angle` changes only on the HANDOFF exit edge (or while in IDLE under `home`). It is constant from SETTLE through HANDOFF of each line.
- Line period with `line_ready` held high is SETTLE_CYCLES + TX_CYCLES + RX_CYCLES + 1. With default parameters that is 22051 cycles. Each cycle `line_ready` is low adds one cycle.
- Markers per line: floor((RX_CYCLES-1)/CM_CYCLES). With default parameters that is 30.
- `transmit`, `receive` and `line_valid` are mutually exclusive and are never high in the same cycle.
- Reset is asynchronous to `clock`. Its release is synchronous: the first active edge after resetn goes high evaluates IDLE.

## Test plan
All scenarios use reduced parameters: SETTLE=4, TX=2, RX=10, CM=3, ANGLE_MAX=3.
- **Free-run line shape.** Reset, then `on`=1 and `line_ready`=1 → per line:
  - `increment` high for 1 cycle.
  - 3 idle settle cycles.
  - `transmit` high for 2 cycles.
  - `receive` high for 10 cycles, with `markers` at RX cycles 3, 6 and 9 and `z_on` during RX cycles 3–9.
  - `line_valid` high for 1 cycle.
  - Period 17 cycles.
- **Bounce sequence.** Free-run for 8 lines → `line_angle` sequence 0,1,2,3,2,1,0,1.
- **Backpressure.** Hold `line_ready`=0 for 5 cycles in HANDOFF → `line_valid` stays high for 6 cycles, `line_angle` stays unchanged, no `increment` occurs, and the next line starts 5 cycles later.
- **Stop.** Drop `on` mid-RX → RX completes, one `line_valid` handshake occurs, then IDLE with all gates at 0. Re-raising `on` restarts the sweep at the held angle, with no step on entry.
- **Async reset.** Assert resetn=0 mid-TX, asynchronously → `transmit` goes to 0 immediately. After release and `on`=1, the first line has `line_angle`=0.
- **Home.** With the angle at 2 going down, assert `home` during the handoff → the next line has angle 0 and the following line has angle 1.
